// File: rtl/pspin_reg_if_arb.sv
// Round-robin arbiter that shares one register-interface target among NUM_PORTS masters.
// Keeps a single downstream transaction outstanding and turns a missing ack into an error response.
module pspin_reg_if_arb #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int TIMEOUT    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  s_reg_rd_addr,
  input  logic [NUM_PORTS-1:0]             s_reg_rd_en,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  s_reg_rd_data,
  output logic [NUM_PORTS-1:0]             s_reg_rd_ack,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  s_reg_wr_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_reg_wr_data,
  input  logic [NUM_PORTS*STRB_WIDTH-1:0]  s_reg_wr_strb,
  input  logic [NUM_PORTS-1:0]             s_reg_wr_en,
  output logic [NUM_PORTS-1:0]             s_reg_wr_ack,
  output logic [ADDR_WIDTH-1:0]            m_reg_rd_addr,
  output logic                             m_reg_rd_en,
  input  logic [DATA_WIDTH-1:0]            m_reg_rd_data,
  input  logic                             m_reg_rd_ack,
  output logic [ADDR_WIDTH-1:0]            m_reg_wr_addr,
  output logic [DATA_WIDTH-1:0]            m_reg_wr_data,
  output logic [STRB_WIDTH-1:0]            m_reg_wr_strb,
  output logic                             m_reg_wr_en,
  input  logic                             m_reg_wr_ack,
  output logic                             busy,
  output logic [31:0]                      timeout_count
);

  localparam int N_REQ = 2*NUM_PORTS;
  localparam int IDX_W = $clog2(N_REQ);
  localparam int TMR_W = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q;
  logic [IDX_W-1:0]      grant_q;
  logic [IDX_W-1:0]      last_grant_q;
  logic [TMR_W-1:0]      timer_q;
  logic [31:0]           timeout_count_q;
  logic [ADDR_WIDTH-1:0] m_rd_addr_q;
  logic [ADDR_WIDTH-1:0] m_wr_addr_q;
  logic [DATA_WIDTH-1:0] m_wr_data_q;
  logic [STRB_WIDTH-1:0] m_wr_strb_q;
  logic [NUM_PORTS-1:0]  s_rd_ack_q;
  logic [NUM_PORTS-1:0]  s_wr_ack_q;
  logic [DATA_WIDTH-1:0] s_rd_data_q [NUM_PORTS];

  // Requester-indexed views: even index = port read, odd index = port write.
  logic [N_REQ-1:0]      req;
  logic [ADDR_WIDTH-1:0] req_addr  [N_REQ];
  logic [DATA_WIDTH-1:0] req_wdata [N_REQ];
  logic [STRB_WIDTH-1:0] req_wstrb [N_REQ];
  logic [NUM_PORTS-1:0]  gnt_rd;
  logic [NUM_PORTS-1:0]  gnt_wr;

  logic                  is_rd;
  logic                  hit;
  logic                  expired;
  logic                  finish;

  assign is_rd   = ~grant_q[0];
  assign hit     = is_rd ? m_reg_rd_ack : m_reg_wr_ack;
  assign expired = (timer_q == TMR_W'(TIMEOUT-1));
  assign finish  = (state_q == BUSY) && (hit || expired);

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign req[2*gi]         = s_reg_rd_en[gi];
      assign req[2*gi+1]       = s_reg_wr_en[gi];
      assign req_addr[2*gi]    = s_reg_rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign req_addr[2*gi+1]  = s_reg_wr_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign req_wdata[2*gi]   = '0;
      assign req_wdata[2*gi+1] = s_reg_wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req_wstrb[2*gi]   = '0;
      assign req_wstrb[2*gi+1] = s_reg_wr_strb[gi*STRB_WIDTH +: STRB_WIDTH];
      assign gnt_rd[gi]        = (grant_q == IDX_W'(2*gi));
      assign gnt_wr[gi]        = (grant_q == IDX_W'(2*gi+1));

      // A timed-out read answers with all-ones so the master sees an obvious error value.
      always_ff @(posedge clk) begin
        if (rst) begin
          s_rd_data_q[gi] <= '0;
        end else if (finish && gnt_rd[gi]) begin
          s_rd_data_q[gi] <= m_reg_rd_ack ? m_reg_rd_data : '1;
        end
      end

      assign s_reg_rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = s_rd_data_q[gi];
    end
  endgenerate

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;

  // Cyclic search starting just after the last grant; the first active requester wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = last_grant_q;
    cand       = last_grant_q;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (cand == IDX_W'(N_REQ-1)) ? '0 : cand + IDX_W'(1);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      grant_q         <= '0;
      last_grant_q    <= IDX_W'(N_REQ-1);
      timer_q         <= '0;
      timeout_count_q <= '0;
      m_rd_addr_q     <= '0;
      m_wr_addr_q     <= '0;
      m_wr_data_q     <= '0;
      m_wr_strb_q     <= '0;
      s_rd_ack_q      <= '0;
      s_wr_ack_q      <= '0;
    end else begin
      s_rd_ack_q <= '0;
      s_wr_ack_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q      <= pick_idx;
            last_grant_q <= pick_idx;
            timer_q      <= '0;
            state_q      <= BUSY;
            if (pick_idx[0]) begin
              m_wr_addr_q <= req_addr[pick_idx];
              m_wr_data_q <= req_wdata[pick_idx];
              m_wr_strb_q <= req_wstrb[pick_idx];
            end else begin
              m_rd_addr_q <= req_addr[pick_idx];
            end
          end
        end
        BUSY: begin
          if (finish) begin
            state_q    <= RESP;
            s_rd_ack_q <= gnt_rd;
            s_wr_ack_q <= gnt_wr;
            if (!hit && (timeout_count_q != 32'hFFFF_FFFF)) begin
              timeout_count_q <= timeout_count_q + 32'd1;
            end
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_reg_rd_en   = (state_q == BUSY) && is_rd;
  assign m_reg_wr_en   = (state_q == BUSY) && !is_rd;
  assign m_reg_rd_addr = m_rd_addr_q;
  assign m_reg_wr_addr = m_wr_addr_q;
  assign m_reg_wr_data = m_wr_data_q;
  assign m_reg_wr_strb = m_wr_strb_q;
  assign s_reg_rd_ack  = s_rd_ack_q;
  assign s_reg_wr_ack  = s_wr_ack_q;
  assign busy          = (state_q != IDLE);
  assign timeout_count = timeout_count_q;

endmodule

// File: doc/pspin_reg_if_arb.md
# pspin_reg_if_arb

Round-robin arbiter that shares one register-interface target (the PsPIN control register file behind its `reg_*` port) among `NUM_PORTS` register-interface masters, e.g. the host AXI-Lite bridge and on-chip debug/config agents. It serialises read and write requests into single outstanding downstream transactions and returns data and acks to the granted master. A per-transaction timeout converts a missing downstream ack into an error response, so a master never hangs.

## Interface
- `NUM_PORTS`, 2: number of upstream masters (≥1).
- `ADDR_WIDTH`, 16: register address width.
- `DATA_WIDTH`, 32: register data width.
- `STRB_WIDTH`, `DATA_WIDTH/8`: byte-strobe width.
- `TIMEOUT`, 16: cycles in BUSY without downstream ack before error response (≥2).

Ports:
- `clk`  in  1  sole clock, all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_reg_rd_addr`  in  NUM_PORTS*ADDR_WIDTH  per-port read address, port p at slice p.
- `s_reg_rd_en`  in  NUM_PORTS  per-port read request, held until ack.
- `s_reg_rd_data`  out  NUM_PORTS*DATA_WIDTH  per-port read data, valid with ack.
- `s_reg_rd_ack`  out  NUM_PORTS  per-port one-cycle read ack.
- `s_reg_wr_addr`  in  NUM_PORTS*ADDR_WIDTH  per-port write address.
- `s_reg_wr_data`  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- `s_reg_wr_strb`  in  NUM_PORTS*STRB_WIDTH  per-port write strobes.
- `s_reg_wr_en`  in  NUM_PORTS  per-port write request, held until ack.
- `s_reg_wr_ack`  out  NUM_PORTS  per-port one-cycle write ack.
- `m_reg_rd_addr`  out  ADDR_WIDTH  downstream read address.
- `m_reg_rd_en`  out  1  downstream read enable.
- `m_reg_rd_data`  in  DATA_WIDTH  downstream read data, sampled with ack.
- `m_reg_rd_ack`  in  1  downstream read ack.
- `m_reg_wr_addr`  out  ADDR_WIDTH  downstream write address.
- `m_reg_wr_data`  out  DATA_WIDTH  downstream write data.
- `m_reg_wr_strb`  out  STRB_WIDTH  downstream write strobes.
- `m_reg_wr_en`  out  1  downstream write enable.
- `m_reg_wr_ack`  in  1  downstream write ack.
- `busy`  out  1  high in BUSY and RESP.
- `timeout_count`  out  32  saturating count of timed-out transactions.

## Operation
- Requester vector of 2*NUM_PORTS entries: index 2p = port p read, 2p+1 = port p write.
- States: IDLE, BUSY, RESP.
- IDLE: if any requester is active, grant the first active index after `last_grant`, searching cyclically. Register the grant and `last_grant`. Capture the granted port's addr, wr_data and wr_strb into the downstream registers. Go to BUSY. Otherwise stay.
- BUSY:
  - `m_reg_rd_en` = granted-is-read; `m_reg_wr_en` = granted-is-write; both decoded from state and grant registers.
  - On the matching ack (`m_reg_rd_ack` for reads, `m_reg_wr_ack` for writes), capture `m_reg_rd_data` for reads and go to RESP.
  - On no ack after TIMEOUT cycles in BUSY: go to RESP with read data all-ones and increment `timeout_count`. The count saturates at 0xFFFFFFFF.
- RESP: pulse `s_reg_rd_ack[p]` or `s_reg_wr_ack[p]` for exactly one cycle. For reads, drive `s_reg_rd_data` slice p with the captured data. Go to IDLE.
- The non-matching downstream ack is ignored. Acks outside BUSY are ignored.
- A master must drop en the cycle after its ack. In the IDLE cycle that follows, its request is therefore not re-granted.
- A port asserting rd_en and wr_en together is treated as two requesters, served in round-robin order.
- Upstream inputs of non-granted ports are not sampled. Request changes while a port waits are the master's responsibility.
- Reset mid-transaction: return to IDLE and drop the in-flight transaction with no ack issued.

## Timing
- Reset values:
  - state IDLE; `last_grant` = 2*NUM_PORTS-1, so index 0 wins first.
  - all `s_reg_*_ack` 0, `s_reg_rd_data` 0.
  - `m_reg_rd_en`, `m_reg_wr_en` 0; `m_reg_*_addr`, data and strb 0.
  - `busy` 0, `timeout_count` 0, timeout counter 0.
- Request first seen in IDLE at cycle 0: downstream en high from cycle 1.
- Downstream ack at cycle 1+k (k≥0): en high through cycle 1+k and low at 2+k. Upstream ack at 2+k.
- Back-to-back throughput: one transaction per k+3 cycles.
- Timeout: en high for cycles 1..TIMEOUT. With no ack, RESP at TIMEOUT+1, en low from TIMEOUT+1. An ack arriving in cycle TIMEOUT wins over the timeout.
- Only one downstream transaction is ever outstanding. `m_reg_rd_en` and `m_reg_wr_en` are never high together.

## Test plan
- Port 0 read of addr 0x1004, downstream acks 2 cycles after en with data 0xCAFEF00D -> `s_reg_rd_ack[0]` pulses once, slice 0 = 0xCAFEF00D, `m_reg_rd_en` high exactly 3 cycles.
- Port 0 write and port 1 write asserted together from reset, immediate downstream acks -> port 0 served first, then port 1. Each `m_reg_wr_addr`, data and strb match its own port.
- Port 1 asserts rd_en and wr_en together while port 0 holds wr_en continuously -> grant order follows round-robin: p0.wr, p1.rd, p1.wr, p0.wr. No requester is starved.
- Downstream never acks a read, TIMEOUT=16 -> ack at cycle 17 with data 0xFFFFFFFF, `timeout_count`=1. The next transaction proceeds normally.
- `rst` asserted in BUSY during a write -> no upstream ack. All outputs return to reset values the following cycle. The first post-reset grant goes to index 0.
- Stray `m_reg_wr_ack` while IDLE, and `m_reg_wr_ack` during a read -> ignored. The read completes only on `m_reg_rd_ack`.
